// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid buffer register: the three-state occupancy encoding.
package skid_buffer_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] ENC_EMPTY = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ENC_BUSY  = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ENC_FULL  = 2'd2;

  typedef enum logic [STATE_WIDTH-1:0] {
    EMPTY = ENC_EMPTY,
    BUSY  = ENC_BUSY,
    FULL  = ENC_FULL
  } skid_state_t;

endpackage

// File: rtl/skid_buffer_control.sv
// Occupancy FSM for the skid buffer: registered handshake outputs plus combinational
// load/select strobes for the data registers. Optional flush port under SKID_BUFFER_CLEAR_EN.
module skid_buffer_control
  import skid_buffer_pkg::*;
(
  input  logic clock,
  input  logic reset,
`ifdef SKID_BUFFER_CLEAR_EN
  input  logic i_clear,
`endif
  input  logic i_input_valid,
  input  logic i_output_ready,
  output logic o_input_ready,
  output logic o_output_valid,
  output logic o_load_main_c,
  output logic o_load_skid_c,
  output logic o_sel_skid_c
);

  skid_state_t r_state;
  skid_state_t w_next_state;
  logic        r_input_ready;
  logic        r_output_valid;
  logic        w_in_fire;
  logic        w_out_fire;

  assign w_in_fire  = i_input_valid & r_input_ready;
  assign w_out_fire = r_output_valid & i_output_ready;

  // State and registered handshake outputs, both derived from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= EMPTY;
      r_input_ready  <= 1'b0;
      r_output_valid <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_input_ready  <= (w_next_state != FULL);
      r_output_valid <= (w_next_state != EMPTY);
    end
  end

  always_comb begin
    w_next_state  = r_state;
    o_load_main_c = 1'b0;
    o_load_skid_c = 1'b0;
    o_sel_skid_c  = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_next_state  = BUSY;
          o_load_main_c = 1'b1;
        end
      end
      BUSY: begin
        if (w_in_fire && !w_out_fire) begin
          w_next_state  = FULL;
          o_load_skid_c = 1'b1;
        end else if (w_in_fire && w_out_fire) begin
          o_load_main_c = 1'b1;
        end else if (w_out_fire) begin
          w_next_state  = EMPTY;
        end
      end
      FULL: begin
        // input_ready is low here, so only the drain of the skid word can happen.
        if (w_out_fire) begin
          w_next_state  = BUSY;
          o_load_main_c = 1'b1;
          o_sel_skid_c  = 1'b1;
        end
      end
      default: w_next_state = EMPTY;
    endcase
`ifdef SKID_BUFFER_CLEAR_EN
    if (i_clear) begin
      w_next_state  = EMPTY;
      o_load_main_c = 1'b0;
      o_load_skid_c = 1'b0;
      o_sel_skid_c  = 1'b0;
    end
`endif
  end

  assign o_input_ready  = r_input_ready;
  assign o_output_valid = r_output_valid;

endmodule

// File: rtl/skid_buffer_register.sv
// Valid/ready pipeline register with a 2-entry skid (main + skid) so input_ready is registered.
// Optional synchronous flush port "clear" when SKID_BUFFER_CLEAR_EN is defined.
module skid_buffer_register
  import skid_buffer_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH  = 10,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef SKID_BUFFER_CLEAR_EN
  input  logic                  clear,
`endif
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [WORD_WIDTH-1:0] input_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] output_data
);

  logic                  w_load_main;
  logic                  w_load_skid;
  logic                  w_sel_skid;
  logic [WORD_WIDTH-1:0] w_main_next;
  logic [WORD_WIDTH-1:0] r_main;
  logic [WORD_WIDTH-1:0] r_skid;

  skid_buffer_control u_control (
    .clock          (clock),
    .reset          (reset),
`ifdef SKID_BUFFER_CLEAR_EN
    .i_clear        (clear),
`endif
    .i_input_valid  (input_valid),
    .i_output_ready (output_ready),
    .o_input_ready  (input_ready),
    .o_output_valid (output_valid),
    .o_load_main_c  (w_load_main),
    .o_load_skid_c  (w_load_skid),
    .o_sel_skid_c   (w_sel_skid)
  );

  assign w_main_next = w_sel_skid ? r_skid : input_data;

  // Data registers only change on an explicit load strobe (or reset/flush).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main <= RESET_VALUE;
      r_skid <= RESET_VALUE;
    end
`ifdef SKID_BUFFER_CLEAR_EN
    else if (clear) begin
      r_main <= RESET_VALUE;
      r_skid <= RESET_VALUE;
    end
`endif
    else begin
      if (w_load_main) r_main <= w_main_next;
      if (w_load_skid) r_skid <= input_data;
    end
  end

  assign output_data = r_main;

endmodule

// File: tb/tb_skid_buffer_register.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// literal checks. Exercises the flush port when SKID_BUFFER_CLEAR_EN is defined.
module tb_skid_buffer_register;

  localparam int unsigned W = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         clear = 1'b0;
  logic         input_valid = 1'b0;
  logic         input_ready;
  logic [W-1:0] input_data = '0;
  logic         output_valid;
  logic         output_ready = 1'b0;
  logic [W-1:0] output_data;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  logic [W-1:0] q[$];
  logic         m_ready = 1'b0;

  skid_buffer_register #(.WORD_WIDTH(W), .RESET_VALUE('0)) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef SKID_BUFFER_CLEAR_EN
    .clear        (clear),
`endif
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two words; ready means fewer than two held.
  always @(posedge clock or posedge reset) begin
    bit in_f, out_f;
    if (reset) begin
      q.delete();
      m_ready = 1'b0;
    end else if (clear) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      in_f  = input_valid && m_ready;
      out_f = (q.size() > 0) && output_ready;
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(input_data);
      m_ready = (q.size() < 2);
    end
  end

  always @(negedge clock) begin
    if (!done) begin
      chk("model_valid", 32'(output_valid), 32'(q.size() > 0));
      chk("model_ready", 32'(input_ready), 32'(m_ready));
      if (q.size() > 0) chk("model_data", 32'(output_data), 32'(q[0]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fill_full(input logic [W-1:0] a, input logic [W-1:0] b);
    output_ready = 1'b0;
    input_valid  = 1'b1;
    input_data   = a;
    tick();
    input_data   = b;
    tick();
    input_valid  = 1'b0;
  endtask

  initial begin
    int pv, pr;
`ifndef SKID_BUFFER_CLEAR_EN
    clear = 1'b0;
`endif
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", 32'(output_valid), 32'd0);
    chk("rst_ready", 32'(input_ready), 32'd0);
    chk("rst_data", 32'(output_data), 32'd0);
    tick(); tick();
    reset = 1'b0;
    chk("rel_ready_low", 32'(input_ready), 32'd0);
    tick();
    chk("rel_ready_high", 32'(input_ready), 32'd1);

    // Streaming 0x001..0x010 with no back-pressure.
    output_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      input_valid = 1'b1;
      input_data  = W'(i);
      tick();
      chk("stream_valid", 32'(output_valid), 32'd1);
      chk("stream_data", 32'(output_data), 32'(i));
      chk("stream_ready", 32'(input_ready), 32'd1);
    end
    input_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(output_valid), 32'd0);

    // Stall: two words fill main + skid.
    fill_full(W'(10'h0AA), W'(10'h0BB));
    chk("stall_ready", 32'(input_ready), 32'd0);
    chk("stall_data", 32'(output_data), 32'h0AA);
    tick();
    chk("stall_hold", 32'(output_data), 32'h0AA);
    output_ready = 1'b1;
    tick();
    chk("unstall_data", 32'(output_data), 32'h0BB);
    chk("unstall_ready", 32'(input_ready), 32'd1);
    tick();
    chk("unstall_empty", 32'(output_valid), 32'd0);

    // Simultaneous in/out fire while BUSY.
    input_valid = 1'b1;
    input_data  = W'(10'h123);
    tick();
    input_data  = W'(10'h0C4);
    tick();
    chk("simul_valid", 32'(output_valid), 32'd1);
    chk("simul_data", 32'(output_data), 32'h0C4);
    chk("simul_ready", 32'(input_ready), 32'd1);
    input_valid = 1'b0;
    tick();

    // Reset asserted while FULL.
    fill_full(W'(10'h155), W'(10'h2AA));
    chk("pre_rst_full", 32'(input_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", 32'(output_valid), 32'd0);
    chk("midrst_ready", 32'(input_ready), 32'd0);
    chk("midrst_data", 32'(output_data), 32'd0);
    tick();
    reset = 1'b0;
    chk("midrel_ready_low", 32'(input_ready), 32'd0);
    tick();
    chk("midrel_ready_high", 32'(input_ready), 32'd1);

`ifdef SKID_BUFFER_CLEAR_EN
    // Flush while FULL with a word on offer; that word must be dropped.
    fill_full(W'(10'h011), W'(10'h022));
    input_valid = 1'b1;
    input_data  = W'(10'h033);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    input_valid = 1'b0;
    chk("clr_valid", 32'(output_valid), 32'd0);
    chk("clr_ready", 32'(input_ready), 32'd1);
    chk("clr_data", 32'(output_data), 32'd0);
    tick();
    chk("clr_dropped", 32'(output_valid), 32'd0);
`endif

    // Randomized traffic with varying valid/ready densities.
    for (int c = 0; c < 10000; c++) begin
      pv = 25 + 25 * ((c / 1000) % 4);
      pr = 100 - 25 * ((c / 700) % 4);
      input_valid  = ($urandom_range(99) < pv);
      output_ready = ($urandom_range(99) < pr);
      input_data   = W'($urandom);
      tick();
    end
    input_valid  = 1'b0;
    output_ready = 1'b1;
    tick(); tick(); tick();
    chk("final_empty", 32'(output_valid), 32'd0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
